// File: rtl/pwm_fade_pkg.sv
// pwm_fade_pkg: shared FSM states, default sizes and duty_bus packing helpers
package pwm_fade_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, SWEEP} state_t;
  localparam int NCH_D = 10;
  localparam int DW_D = 8;
  typedef logic [NCH_D-1:0][DW_D-1:0] duty_arr_t;
  function automatic logic [NCH_D*DW_D-1:0] pack_duty(input duty_arr_t a);
    return a;
  endfunction
  function automatic duty_arr_t unpack_duty(input logic [NCH_D*DW_D-1:0] b);
    return b;
  endfunction
endpackage

// File: rtl/fade_step_unit.sv
// fade_step_unit: moves c toward t by at most STEP without overshoot
module fade_step_unit #(
  parameter int DW = 8,
  parameter int STEP = 4
) (
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] t,
  output logic [DW-1:0] n
);
  logic up;
  logic [DW:0] d, s;
  always_comb begin
    up = t > c;
    d = up ? {1'b0, t} - {1'b0, c} : {1'b0, c} - {1'b0, t};
    s = d > (DW+1)'(STEP) ? (DW+1)'(STEP) : d;
    n = DW'(up ? {1'b0, c} + s : {1'b0, c} - s);
  end
endmodule

// File: rtl/pwm_fade_scheduler.sv
// pwm_fade_scheduler: ramps PWM duties toward targets, one channel per clock, once per tick
module pwm_fade_scheduler
  import pwm_fade_pkg::*;
#(
  parameter int NCH = NCH_D,
  parameter int DW = DW_D,
  parameter int STEP = 4,
  parameter int TICK_DIV = 250000
) (
  input  logic              clk25M,
  input  logic              rst_n,
  input  logic [NCH*DW-1:0] target_bus,
  input  logic              target_valid,
  input  logic              snap,
  output logic [NCH*DW-1:0] duty_bus,
  output logic              busy,
  output logic              done
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
  state_t state;
  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic [NCH-1:0][DW-1:0] cur, tgt, cur_nxt, tgt_nxt;
  logic [DW-1:0] step_c;
  logic tick;
  assign tick = pre == PW'(TICK_DIV - 1);
  assign duty_bus = cur;
  fade_step_unit #(.DW(DW), .STEP(STEP)) u_step (.c(cur[idx]), .t(tgt[idx]), .n(step_c));
  // end-of-sweep decision looks at the values this edge will leave behind
  always_comb begin
    cur_nxt = cur;
    cur_nxt[idx] = step_c;
    tgt_nxt = target_valid ? target_bus : tgt;
  end
  always_ff @(posedge clk25M or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pre <= '0;
      idx <= '0;
      cur <= '0;
      tgt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      pre <= tick ? '0 : pre + 1'b1;
      if (target_valid) tgt <= target_bus;
      if (snap) begin
        cur <= tgt_nxt;
        state <= IDLE;
        idx <= '0;
        busy <= 1'b0;
        done <= busy;
      end else begin
        case (state)
          IDLE: if (cur != tgt) begin
            state <= WAIT;
            busy <= 1'b1;
          end
          WAIT: if (tick) begin
            state <= SWEEP;
            idx <= '0;
          end
          SWEEP: begin
            cur <= cur_nxt;
            if (idx == IW'(NCH - 1)) begin
              idx <= '0;
              if (cur_nxt != tgt_nxt) state <= WAIT;
              else begin
                state <= IDLE;
                busy <= 1'b0;
                done <= 1'b1;
              end
            end else idx <= idx + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
